// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and constants for the fetch instruction queue: packet layout,
// NOP encoding and slot PC helpers.
package fetch_inst_queue_pkg;

  localparam logic [31:0] INST_NOP  = 32'h0340_0000;
  localparam logic [31:0] PC_RESET  = 32'h1c00_0000;
  localparam logic [1:0]  EXCP_NONE = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] badv;
    logic [6:0]  exception;
    logic [1:0]  excp_flag;
  } fetch_data_t;

  // The slot mask lives apart from the payload so it can be cleared on reset/flush.
  typedef struct packed {
    fetch_data_t data;
    logic [1:0]  mask;
  } fetch_pkt_t;

  function automatic logic [31:0] slot_pc(input logic [31:0] pc, input logic slot);
    slot_pc = (pc & 32'hFFFF_FFF8) | {29'd0, slot, 2'b00};
  endfunction

  function automatic logic first_slot(input logic [1:0] mask);
    first_slot = ~mask[0];
  endfunction

endpackage

// File: rtl/fetch_inst_queue_if.sv
// IF1 -> queue -> decode handshake bundle.
interface fetch_inst_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_pc_next;
  logic [31:0] in_inst0;
  logic [31:0] in_inst1;
  logic [31:0] in_badv;
  logic [6:0]  in_exception;
  logic [1:0]  in_excp_flag;
  logic [1:0]  out_valid;
  logic [31:0] out_pc0;
  logic [31:0] out_pc1;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic [1:0]  out_excp_flag0;
  logic [6:0]  out_exception0;
  logic [31:0] out_badv0;
  logic [1:0]  dec_take;

  modport master (
    output in_valid, in_pc, in_pc_next, in_inst0, in_inst1, in_badv, in_exception,
           in_excp_flag, dec_take,
    input  in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1, out_excp_flag0,
           out_exception0, out_badv0
  );

  modport slave (
    input  in_valid, in_pc, in_pc_next, in_inst0, in_inst1, in_badv, in_exception,
           in_excp_flag, dec_take,
    output in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1, out_excp_flag0,
           out_exception0, out_badv0
  );
endinterface

// File: rtl/fetch_inst_queue_chk.sv
// Protocol checks on the decode side of the fetch instruction queue.
module fetch_inst_queue_chk (
  input logic       clk,
  input logic       rstn,
  input logic [1:0] dec_take,
  input logic [1:0] out_valid
);
  logic [1:0] w_lanes;

  assign w_lanes = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};

  a_take_legal: assert property (@(posedge clk) disable iff (!rstn) dec_take <= w_lanes);
  a_lane_order: assert property (@(posedge clk) disable iff (!rstn) out_valid != 2'b10);
endmodule

// File: rtl/fetch_inst_queue_lane_select.sv
// Forms the two decode lanes from the head entry and the entry behind it,
// and reports where each lane came from so the queue can retire it.
import fetch_inst_queue_pkg::*;

module ifq_lane_select (
  input  fetch_pkt_t  i_head,
  input  logic        i_head_vld,
  input  logic [31:0] i_nxt_pc,
  input  logic [31:0] i_nxt_inst0,
  input  logic [31:0] i_nxt_inst1,
  input  logic [1:0]  i_nxt_excp_flag,
  input  logic [1:0]  i_nxt_mask,
  input  logic        i_nxt_vld,
  output logic [1:0]  o_valid,
  output logic [31:0] o_pc0,
  output logic [31:0] o_pc1,
  output logic [31:0] o_inst0,
  output logic [31:0] o_inst1,
  output logic [1:0]  o_excp_flag0,
  output logic [6:0]  o_exception0,
  output logic [31:0] o_badv0,
  output logic        o_l0_slot,
  output logic        o_l1_nxt,
  output logic        o_l1_slot
);
  logic w_l0_vld;
  logic w_l0_slot;
  logic w_pair;
  logic w_nxt_ok;
  logic w_nxt_slot;

  assign w_l0_vld   = i_head_vld && (i_head.mask != 2'b00);
  assign w_l0_slot  = first_slot(i_head.mask);
  assign w_pair     = (i_head.mask == 2'b11);
  assign w_nxt_slot = first_slot(i_nxt_mask);
  // Excepting packets are single-slot, so they can never pair with a neighbour.
  assign w_nxt_ok   = i_nxt_vld && (i_nxt_mask != 2'b00) &&
                      (i_head.data.excp_flag == EXCP_NONE) && (i_nxt_excp_flag == EXCP_NONE);

  // Lane multiplexing; invalid lanes show NOP at PC zero.
  always_comb begin
    o_valid      = 2'b00;
    o_pc0        = 32'd0;
    o_inst0      = INST_NOP;
    o_excp_flag0 = EXCP_NONE;
    o_exception0 = 7'd0;
    o_badv0      = 32'd0;
    o_pc1        = 32'd0;
    o_inst1      = INST_NOP;
    o_l0_slot    = w_l0_slot;
    o_l1_nxt     = 1'b0;
    o_l1_slot    = 1'b1;
    if (w_l0_vld) begin
      o_valid[0]   = 1'b1;
      o_pc0        = slot_pc(i_head.data.pc, w_l0_slot);
      o_inst0      = w_l0_slot ? i_head.data.inst1 : i_head.data.inst0;
      o_excp_flag0 = i_head.data.excp_flag;
      o_exception0 = i_head.data.exception;
      o_badv0      = i_head.data.badv;
      if (w_pair) begin
        o_valid[1] = 1'b1;
        o_pc1      = slot_pc(i_head.data.pc, 1'b1);
        o_inst1    = i_head.data.inst1;
      end else if (w_nxt_ok) begin
        o_valid[1] = 1'b1;
        o_l1_nxt   = 1'b1;
        o_l1_slot  = w_nxt_slot;
        o_pc1      = slot_pc(i_nxt_pc, w_nxt_slot);
        o_inst1    = w_nxt_slot ? i_nxt_inst1 : i_nxt_inst0;
      end else begin
        o_valid[1] = 1'b0;
      end
    end else begin
      o_valid = 2'b00;
    end
  end
endmodule

// File: rtl/fetch_inst_queue.sv
// Packet-granularity instruction queue between IF1 and decode; strips
// invalid slots and hands up to two instructions per cycle to decode.
import fetch_inst_queue_pkg::*;

module fetch_inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rstn,
  input logic               flush,
  fetch_inst_queue_if.slave bus
);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fetch_data_t               r_data [DEPTH];
  logic [DEPTH-1:0][1:0]     r_mask;
  logic [PTR_W-1:0]          r_rd;
  logic [PTR_W-1:0]          r_wr;
  logic [PTR_W:0]            r_count;

  logic [PTR_W-1:0] w_nxt;
  fetch_pkt_t       w_head;
  fetch_data_t      w_in_data;
  logic [1:0]       w_in_mask;
  logic             w_push;
  logic             w_l0_slot;
  logic             w_l1_nxt;
  logic             w_l1_slot;
  logic [1:0]       w_head_clr;
  logic [1:0]       w_nxt_clr;
  logic [1:0]       w_head_new;
  logic [1:0]       w_nxt_new;
  logic [1:0]       w_pops;

  assign w_nxt        = r_rd + PTR_ONE;
  assign w_head       = {r_data[r_rd], r_mask[r_rd]};
  assign bus.in_ready = (r_count < CNT_FULL);
  assign w_in_data    = '{pc: bus.in_pc, inst0: bus.in_inst0, inst1: bus.in_inst1,
                          badv: bus.in_badv, exception: bus.in_exception,
                          excp_flag: bus.in_excp_flag};
  assign w_push       = bus.in_valid && bus.in_ready && (w_in_mask != 2'b00);

  // Entry slot mask: an exception keeps only the first live slot.
  always_comb begin
    w_in_mask[0] = ~bus.in_pc[2];
    w_in_mask[1] = bus.in_pc[2] || (bus.in_pc_next != (bus.in_pc + 32'd4));
    if ((bus.in_excp_flag != EXCP_NONE) && w_in_mask[0]) begin
      w_in_mask[1] = 1'b0;
    end else begin
      w_in_mask[1] = w_in_mask[1];
    end
  end

  ifq_lane_select u_lane_select (
    .i_head         (w_head),
    .i_head_vld     (r_count != '0),
    .i_nxt_pc       (r_data[w_nxt].pc),
    .i_nxt_inst0    (r_data[w_nxt].inst0),
    .i_nxt_inst1    (r_data[w_nxt].inst1),
    .i_nxt_excp_flag(r_data[w_nxt].excp_flag),
    .i_nxt_mask     (r_mask[w_nxt]),
    .i_nxt_vld      (r_count > (PTR_W + 1)'(1)),
    .o_valid        (bus.out_valid),
    .o_pc0          (bus.out_pc0),
    .o_pc1          (bus.out_pc1),
    .o_inst0        (bus.out_inst0),
    .o_inst1        (bus.out_inst1),
    .o_excp_flag0   (bus.out_excp_flag0),
    .o_exception0   (bus.out_exception0),
    .o_badv0        (bus.out_badv0),
    .o_l0_slot      (w_l0_slot),
    .o_l1_nxt       (w_l1_nxt),
    .o_l1_slot      (w_l1_slot)
  );

  // Retire consumed slots; an entry pops once its mask drains to zero.
  always_comb begin
    w_head_clr = 2'b00;
    w_nxt_clr  = 2'b00;
    if ((bus.dec_take != 2'd0) && bus.out_valid[0]) begin
      w_head_clr[w_l0_slot] = 1'b1;
    end else begin
      w_head_clr = 2'b00;
    end
    if ((bus.dec_take == 2'd2) && bus.out_valid[1]) begin
      if (w_l1_nxt) begin
        w_nxt_clr[w_l1_slot] = 1'b1;
      end else begin
        w_head_clr[w_l1_slot] = 1'b1;
      end
    end else begin
      w_nxt_clr = 2'b00;
    end
    w_head_new = w_head.mask & ~w_head_clr;
    w_nxt_new  = r_mask[w_nxt] & ~w_nxt_clr;
    w_pops     = {1'b0, (w_head_clr != 2'b00) && (w_head_new == 2'b00)} +
                 {1'b0, (w_nxt_clr != 2'b00) && (w_nxt_new == 2'b00)};
  end

  // Queue state; flush shares the reset path and beats any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_mask  <= '0;
    end else begin
      if (w_head_clr != 2'b00) r_mask[r_rd] <= w_head_new;
      if (w_nxt_clr != 2'b00)  r_mask[w_nxt] <= w_nxt_new;
      if (w_push) begin
        r_data[r_wr] <= w_in_data;
        r_mask[r_wr] <= w_in_mask;
      end
      r_rd    <= r_rd + PTR_W'(w_pops);
      r_wr    <= r_wr + PTR_W'(w_push);
      r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pops);
    end
  end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: live slots are queued when a packet
// is accepted and compared against the lanes decode sees each cycle.
module tb_fetch_inst_queue;
  import fetch_inst_queue_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fetch_inst_queue_if bus ();

  fetch_inst_queue #(.DEPTH(8)) dut (.clk(clk), .rstn(rstn), .flush(flush), .bus(bus));

  fetch_inst_queue_chk u_chk (.clk(clk), .rstn(rstn), .dec_take(bus.dec_take),
                              .out_valid(bus.out_valid));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] badv;
    logic [6:0]  exc;
    logic [1:0]  ef;
    logic        last;
  } item_t;

  item_t sb[$];
  int    pkt_cnt = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    model_ok = 1'b0;

  logic        d_v = 1'b0;
  logic [31:0] d_pc, d_pcn, d_i0, d_i1, d_badv;
  logic [6:0]  d_exc;
  logic [1:0]  d_ef;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lanes();
    if (sb.size() == 0) return 0;
    if (sb.size() > 1 && sb[0].ef == 2'b00 && sb[1].ef == 2'b00) return 2;
    return 1;
  endfunction

  task automatic compare_outputs(input string tag);
    int          n;
    logic [31:0] e_pc0, e_i0, e_badv, e_pc1, e_i1;
    logic [6:0]  e_exc;
    logic [1:0]  e_ef;
    n = lanes();
    e_pc0 = 32'd0; e_i0 = INST_NOP; e_badv = 32'd0; e_exc = 7'd0; e_ef = 2'b00;
    e_pc1 = 32'd0; e_i1 = INST_NOP;
    if (n >= 1) begin
      e_pc0 = sb[0].pc; e_i0 = sb[0].inst; e_badv = sb[0].badv; e_exc = sb[0].exc; e_ef = sb[0].ef;
    end
    if (n == 2) begin
      e_pc1 = sb[1].pc; e_i1 = sb[1].inst;
    end
    check({tag, ".ready"}, 32'(bus.in_ready), 32'(pkt_cnt < 8));
    check({tag, ".valid"}, 32'(bus.out_valid), (n == 2) ? 32'd3 : 32'(n));
    check({tag, ".pc0"},   bus.out_pc0, e_pc0);
    check({tag, ".inst0"}, bus.out_inst0, e_i0);
    check({tag, ".ef0"},   32'(bus.out_excp_flag0), 32'(e_ef));
    check({tag, ".exc0"},  32'(bus.out_exception0), 32'(e_exc));
    check({tag, ".badv0"}, bus.out_badv0, e_badv);
    check({tag, ".pc1"},   bus.out_pc1, e_pc1);
    check({tag, ".inst1"}, bus.out_inst1, e_i1);
  endtask

  task automatic set_pkt(input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [1:0] ef = 2'b00,
                         input logic [6:0] exc = 7'd0, input logic [31:0] badv = 32'd0);
    d_v = 1'b1; d_pc = pc; d_pcn = pcn; d_i0 = i0; d_i1 = i1; d_ef = ef; d_exc = exc; d_badv = badv;
  endtask

  // One clock: compare the lanes, drive the inputs, then advance the model.
  task automatic tick(input string tag, input logic [1:0] take, input logic fl = 1'b0,
                      input logic rn = 1'b1);
    bit    rdy, s0, s1;
    item_t it;
    @(negedge clk);
    if (model_ok) compare_outputs(tag);
    bus.in_valid = d_v; bus.in_pc = d_pc; bus.in_pc_next = d_pcn;
    bus.in_inst0 = d_i0; bus.in_inst1 = d_i1; bus.in_badv = d_badv;
    bus.in_exception = d_exc; bus.in_excp_flag = d_ef; bus.dec_take = take;
    flush = fl; rstn = rn;
    if (!rn || fl) begin
      sb.delete();
      pkt_cnt = 0;
      model_ok = 1'b1;
    end else begin
      rdy = (pkt_cnt < 8);
      for (int k = 0; k < int'(take); k++) begin
        if (sb.size() > 0) begin
          it = sb.pop_front();
          if (it.last) pkt_cnt--;
        end
      end
      s0 = !d_pc[2];
      s1 = d_pc[2] || (d_pcn != d_pc + 32'd4);
      if (d_ef != 2'b00 && s0) s1 = 1'b0;
      if (d_v && rdy && (s0 || s1)) begin
        pkt_cnt++;
        it.badv = d_badv; it.exc = d_exc; it.ef = d_ef;
        if (s0) begin
          it.pc = {d_pc[31:3], 3'b000}; it.inst = d_i0; it.last = !s1;
          sb.push_back(it);
        end
        if (s1) begin
          it.pc = {d_pc[31:3], 3'b100}; it.inst = d_i1; it.last = 1'b1;
          sb.push_back(it);
        end
      end
    end
    d_v = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 40 && sb.size() > 0; g++) tick(tag, 2'(lanes()));
  endtask

  initial begin
    logic [31:0] rpc, rpcn;
    d_pc = 32'd0; d_pcn = 32'd0; d_i0 = 32'd0; d_i1 = 32'd0; d_badv = 32'd0; d_exc = 7'd0; d_ef = 2'b00;
    bus.in_valid = 1'b0; bus.dec_take = 2'd0;
    tick("rst", 2'd0, 1'b0, 1'b0);
    tick("rst", 2'd0, 1'b0, 1'b0);

    // Full pair in, both lanes taken.
    set_pkt(PC_RESET, 32'h1c00_0008, 32'hA000_0001, 32'hB000_0002);
    tick("t1_push", 2'd0);
    tick("t1_pair", 2'd2);
    tick("t1_empty", 2'd0);

    // Slot1-only packet pairs with the following packet's slot0.
    set_pkt(32'h1c00_0004, 32'h1c00_0008, 32'hDEAD_0000, 32'hB000_0012);
    tick("t2_push0", 2'd0);
    set_pkt(32'h1c00_0008, 32'h1c00_0010, 32'hC000_0013, 32'hD000_0014);
    tick("t2_push1", 2'd0);
    tick("t2_cross", 2'd2);
    tick("t2_tail", 2'd1);
    tick("t2_empty", 2'd0);

    // Fill to full, overflow attempt, then push+take while full.
    for (int i = 0; i < 9; i++) begin
      set_pkt(32'h1c00_1000 + 32'(8 * i), 32'h1c00_1008 + 32'(8 * i), 32'h3000_0000 + 32'(i),
              32'h3100_0000 + 32'(i));
      tick("t3_fill", 2'd0);
    end
    for (int i = 0; i < 4; i++) begin
      set_pkt(32'h1c00_2000 + 32'(8 * i), 32'h1c00_2008 + 32'(8 * i), 32'h3200_0000 + 32'(i),
              32'h3300_0000 + 32'(i));
      tick("t3_full", 2'd2);
    end
    drain("t3_drain");

    // Exception packet behind a single-slot packet stays alone on lane0.
    set_pkt(32'h1c00_0104, 32'h1c00_0108, 32'h0, 32'h4000_0001);
    tick("t4_push0", 2'd0);
    set_pkt(32'h1c00_0010, 32'h1c00_0018, 32'h4000_0002, 32'h4000_0003, 2'b01, 7'h08, 32'h1c00_0010);
    tick("t4_push1", 2'd0);
    tick("t4_noln1", 2'd1);
    tick("t4_excp", 2'd1);
    tick("t4_empty", 2'd0);

    // Flush with a concurrent push and pop.
    for (int i = 0; i < 5; i++) begin
      set_pkt(32'h1c00_3000 + 32'(8 * i), 32'h1c00_3008 + 32'(8 * i), 32'h5000_0000 + 32'(i),
              32'h5100_0000 + 32'(i));
      tick("t5_fill", 2'd0);
    end
    set_pkt(32'h1c00_4000, 32'h1c00_4008, 32'h5200_0000, 32'h5300_0000);
    tick("t5_flush", 2'd2, 1'b1);
    tick("t5_after", 2'd0);

    // Reset mid-stream, then resume.
    for (int i = 0; i < 3; i++) begin
      set_pkt(32'h1c00_5000 + 32'(8 * i), 32'h1c00_5008 + 32'(8 * i), 32'h6000_0000 + 32'(i),
              32'h6100_0000 + 32'(i));
      tick("t6_fill", 2'd0);
    end
    tick("t6_rst", 2'd0, 1'b0, 1'b0);
    set_pkt(32'h1c00_6000, 32'h1c00_6008, 32'h6200_0000, 32'h6300_0000);
    tick("t6_after", 2'd0);
    tick("t6_new", 2'd0);
    drain("t6_drain");

    // Random traffic with occasional exceptions, redirects and flushes.
    for (int c = 0; c < 400; c++) begin
      rpc = $urandom();
      rpc[1:0] = 2'b00;
      case ($urandom_range(0, 2))
        0:       rpcn = rpc + 32'd4;
        1:       rpcn = {rpc[31:3], 3'b000} + 32'd8;
        default: begin rpcn = $urandom(); rpcn[1:0] = 2'b00; end
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0)
          set_pkt(rpc, rpcn, $urandom(), $urandom(), 2'($urandom_range(1, 3)), 7'($urandom()), $urandom());
        else
          set_pkt(rpc, rpcn, $urandom(), $urandom());
      end
      tick("rnd", 2'($urandom_range(0, lanes())), ($urandom_range(0, 60) == 0));
    end
    drain("rnd_drain");
    tick("final", 2'd0);
    @(negedge clk);
    compare_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Packet-granularity instruction queue between the IF1 stage register and decode.
- Accepts one fetch packet per cycle from IF1: an aligned 8-byte pair with two instruction slots, plus exception info.
- Strips invalid slots and presents up to two instructions per cycle to decode; decode may take 0, 1 or 2.
- Decouples fetch stalls from decode stalls and absorbs flushes.

Parameters:
DEPTH, 8, number of packet entries; must be a power of two and ≥ 4.
PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
flush  in  1  pipeline flush; clears the whole queue
in_valid  in  1  IF1 packet valid (IF1 readygo)
in_ready  out  1  queue can accept a packet (feeds IF1 allowin)
in_pc  in  32  packet PC; bit 2 set means slot0 is invalid
in_pc_next  in  32  predicted next fetch PC
in_inst0  in  32  slot0 instruction
in_inst1  in  32  slot1 instruction
in_badv  in  32  faulting address
in_exception  in  7  exception code
in_excp_flag  in  2  nonzero means the packet carries an exception
out_valid  out  2  lane-valid bits; bit0 lane0, bit1 lane1
out_pc0  out  32  lane0 PC
out_pc1  out  32  lane1 PC
out_inst0  out  32  lane0 instruction
out_inst1  out  32  lane1 instruction
out_excp_flag0  out  2  lane0 exception flag
out_exception0  out  7  lane0 exception code
out_badv0  out  32  lane0 bad address
dec_take  in  2  lanes consumed this cycle: 0, 1 or 2 (value 3 illegal)

Behaviour:
- Slot mask computed on entry:
  - m0 = !in_pc[2]
  - m1 = in_pc[2] || (in_pc_next != in_pc+4)
  - If in_excp_flag != 0, keep only the first set bit of the mask.
- Storage per entry: pc, inst0, inst1, badv, exception, excp_flag, mask[1:0].
- Slot PCs:
  - slot0 PC = {pc[31:3],3'b000}
  - slot1 PC = {pc[31:3],3'b100}
- Push condition: in_valid && in_ready && mask != 0. A zero-mask packet is accepted and dropped.
- in_ready = (count < DEPTH). It depends on registered state only; there is no combinational path from dec_take.
- Latency: a packet pushed at edge N is visible on the out_* ports after edge N, i.e. during cycle N+1.
- Lane formation (combinational from head entry H and next entry H+1):
  - lane0 = lowest set slot of H.mask.
  - lane1 = second set slot of H if present.
  - Otherwise lane1 = lowest set slot of H+1, but only if H+1 exists, has excp_flag == 0, and H has excp_flag == 0.
  - A lane carrying an exception is always lane0 alone; exception fields are exported on lane0 only.
- Invalid lanes drive inst = INST_NOP and pc = 0. When empty: out_valid = 0, all lane outputs NOP/zero.
- Pop on dec_take:
  - 1: clear lane0's mask bit; if H.mask becomes 0, advance the read pointer.
  - 2, both lanes from H: pop H.
  - 2, lane1 from H+1: pop H, clear that slot in H+1, and also pop H+1 if its mask becomes 0.
  - dec_take greater than popcount(out_valid) is illegal; assert in simulation.
- Count:
  - Width PTR_W+1, wraps through pointers modulo DEPTH.
  - Simultaneous push and pop in the same cycle is legal, including at full (in_ready already 0) and at empty (push-only).
- Flush: synchronous, highest priority. The same-cycle push and pop are discarded; pointers, count and all masks go to 0. in_ready = 1 on the next cycle.
- Reset (rstn = 0): same as flush. out_valid = 0, in_ready = 1 after reset.
- Reset or flush mid-operation leaves no partial entry; entry data payloads need no reset.

Decomposition:
- Shared package / define.vh:
  - INST_NOP, PC_RESET
  - a fetch-packet struct: pc, inst0, inst1, badv, exception, excp_flag, mask
  - EXCP_NONE = 2'b00
- One natural sub-module: ifq_lane_select, combinational.
  - Inputs: head and next entries plus their existence bits.
  - Outputs: out_* lane fields and per-lane source tags (entry, slot), which the top uses for pop/mask-clear.

Test Plan:
1. Push pc=0x1c000000, pc_next=0x1c000008, insts A,B; dec_take=2 next cycle -> out_valid=2'b11, pc0=0x1c000000, pc1=0x1c000004; queue empty after.
2. Push pc=0x1c000004 (inst B only), then pc=0x1c000008 with C,D -> cycle 1 out_valid=11, lanes B@0x1c000004 and C@0x1c000008; after dec_take=2, lane0 = D@0x1c00000c.
3. Push 8 packets with dec_take=0 -> in_ready=0 after the 8th; push+take=2 on a full queue does not overrun; count stays ≤ 8; read pointer wraps correctly on packet 9.
4. Packet with excp_flag=2'b01, exception=7'h08, badv=0x1c000010 behind a single-slot packet -> lane1 invalid; next cycle lane0 carries the exception alone with badv 0x1c000010.
5. Flush asserted together with in_valid and dec_take=2 on a 5-entry queue -> next cycle out_valid=0, in_ready=1, no entry written.
6. rstn low for 1 cycle mid-stream with 3 entries -> out_valid=0, in_ready=1; a new push appears one cycle later.
